// File: rtl/div_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_share_arbiter
// Description : Round-robin sharing of one multi-cycle mantissa divider among
//               NUM_REQ requesters, with operand screening and a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module div_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int INWIDTH  = 24,
  parameter int OUTWIDTH = 24,
  parameter int TIMEOUT  = 64,
  parameter int IDXW     = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*INWIDTH-1:0]  req_dividend,
  input  logic [NUM_REQ*INWIDTH-1:0]  req_divisor,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [OUTWIDTH-1:0]         resp_quotient,
  output logic [INWIDTH-1:0]          resp_remainder,
  output logic                        resp_error,
  output logic [IDXW-1:0]             resp_idx,
  output logic                        div_start,
  output logic [INWIDTH-1:0]          div_dividend,
  output logic [INWIDTH-1:0]          div_divisor,
  input  logic                        div_busy,
  input  logic                        div_done,
  input  logic [OUTWIDTH-1:0]         div_quotient,
  input  logic [INWIDTH-1:0]          div_remainder
);

  localparam int              WDW       = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  c_WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IDXW:0]   c_NREQ    = (IDXW + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDXW-1:0]       r_ptr;
  logic [IDXW-1:0]       r_gidx;
  logic [INWIDTH-1:0]    r_dvd;
  logic [INWIDTH-1:0]    r_dvs;
  logic [OUTWIDTH-1:0]   r_quot;
  logic [INWIDTH-1:0]    r_rem;
  logic                  r_err;
  logic [WDW-1:0]        r_wdog;

  logic                  w_gnt_any;
  logic [IDXW-1:0]       w_gnt_idx;
  logic [IDXW:0]         w_cand;
  logic                  w_grant;
  logic [INWIDTH-1:0]    w_op_a;
  logic [INWIDTH-1:0]    w_op_b;
  logic                  w_op_ok;
  logic                  w_wd_exp;

  // Scan from farthest to nearest so the nearest valid index after r_ptr wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = {1'b0, r_ptr} + (IDXW + 1)'(k);
      if (w_cand >= c_NREQ) begin
        w_cand = w_cand - c_NREQ;
      end
      if (req_valid[w_cand[IDXW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand[IDXW-1:0];
      end
    end
  end

  assign w_grant  = (r_state == S_IDLE) && !div_busy && w_gnt_any;
  assign w_op_a   = req_dividend[int'(w_gnt_idx) * INWIDTH +: INWIDTH];
  assign w_op_b   = req_divisor[int'(w_gnt_idx) * INWIDTH +: INWIDTH];
  assign w_op_ok  = w_op_a[INWIDTH-1] && w_op_b[INWIDTH-1];
  assign w_wd_exp = (r_wdog == c_WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    resp_valid  = '0;
    div_start   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          req_ready[w_gnt_idx] = 1'b1;
          w_state_nxt          = w_op_ok ? S_START : S_RESP;
        end
      end
      S_START: begin
        div_start   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (div_done || w_wd_exp) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid[r_gidx] = 1'b1;
        if (resp_ready[r_gidx]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr  <= IDXW'(NUM_REQ - 1);
      r_gidx <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_err  <= 1'b0;
      r_wdog <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_dvd  <= w_op_a;
            r_dvs  <= w_op_b;
            r_gidx <= w_gnt_idx;
            r_ptr  <= w_gnt_idx;
            if (!w_op_ok) begin
              r_err  <= 1'b1;
              r_quot <= '0;
              r_rem  <= '0;
            end
          end
        end
        S_START: begin
          r_wdog <= '0;
        end
        S_WAIT: begin
          r_wdog <= r_wdog + 1'b1;
          // A done in the expiry cycle still delivers a good result.
          if (div_done) begin
            r_quot <= div_quotient;
            r_rem  <= div_remainder;
            r_err  <= 1'b0;
          end else if (w_wd_exp) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_err  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign resp_quotient  = r_quot;
  assign resp_remainder = r_rem;
  assign resp_error     = r_err;
  assign resp_idx       = r_gidx;
  assign div_dividend   = r_dvd;
  assign div_divisor    = r_dvs;

endmodule
`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_div_share_arbiter
// Description : Randomized and directed bench for div_share_arbiter against a
//               cycle-level scoreboard and a behavioural divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 24;
  localparam int OW = 24;
  localparam int TO = 64;
  localparam int D  = OW + 1;
  localparam int IW = $clog2(N);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_dividend = '0;
  logic [N*W-1:0]   req_divisor = '0;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ready = '0;
  logic [OW-1:0]    resp_quotient;
  logic [W-1:0]     resp_remainder;
  logic             resp_error;
  logic [IW-1:0]    resp_idx;
  logic             div_start;
  logic [W-1:0]     div_dividend;
  logic [W-1:0]     div_divisor;
  logic             div_busy;
  logic             div_done;
  logic [OW-1:0]    div_quotient;
  logic [W-1:0]     div_remainder;

  always #5 clk = ~clk;

  div_share_arbiter #(.NUM_REQ(N), .INWIDTH(W), .OUTWIDTH(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .resp_error(resp_error), .resp_idx(resp_idx),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Normalized mantissa divide: quotient carries OW-1 fraction bits.
  function automatic logic [OW+W-1:0] f_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] n;
    logic [63:0] d;
    n = {40'd0, a} << (OW - 1);
    d = {40'd0, b};
    return {OW'(n / d), W'(n % d)};
  endfunction

  // Behavioural divider: done pulses D cycles after the start cycle.
  int  dm_cnt;
  bit  busy_force = 1'b0;
  bit  m_hang = 1'b0;
  assign div_busy = (dm_cnt != 0) || busy_force;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dm_cnt        <= 0;
      div_done      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else begin
      div_done <= (dm_cnt == 2);
      if (div_start && !m_hang) begin
        dm_cnt <= D;
        {div_quotient, div_remainder} <= f_div(div_dividend, div_divisor);
      end else if (dm_cnt != 0) begin
        dm_cnt <= dm_cnt - 1;
      end
    end
  end

  // Scoreboard: one transaction in flight, tracked by grant cycle and latency.
  int            cyc = 0;
  bit            m_fly = 1'b0;
  bit            m_good;
  bit            m_err;
  int            m_idx, m_gc, m_lat;
  int            m_ptr = N - 1;
  logic [W-1:0]  m_a, m_b, m_r;
  logic [OW-1:0] m_q;
  int            n_done = 0;
  int            glog[$];

  logic [N-1:0]  want = '0;
  logic [W-1:0]  opa[N];
  logic [W-1:0]  opb[N];
  logic [N-1:0]  rr_drv = '0;
  bit            refill = 1'b0;
  bit            rnd_mode = 1'b0;
  int            hang_mode = 0;
  logic [OW-1:0] last_q;
  logic [W-1:0]  last_r;
  logic          last_err;
  logic [IW-1:0] last_idx;

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    v        = W'($urandom);
    v[W-1]   = ($urandom_range(0, 9) != 0);
    return v;
  endfunction

  task automatic step();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    int           g;
    bit           exp_st;
    @(negedge clk);
    cyc++;
    if (rnd_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!want[i] && $urandom_range(0, 3) == 0) begin
          want[i] = 1'b1;
          opa[i]  = rnd_op();
          opb[i]  = rnd_op();
        end else if (want[i] && $urandom_range(0, 31) == 0) begin
          want[i] = 1'b0;
        end
      end
      rr_drv     = N'($urandom);
      busy_force = ($urandom_range(0, 7) == 0);
    end
    req_valid  = want;
    for (int i = 0; i < N; i++) begin
      req_dividend[i*W +: W] = opa[i];
      req_divisor[i*W +: W]  = opb[i];
    end
    resp_ready = rr_drv;
    #1;
    exp_rdy = '0;
    g       = -1;
    if (!m_fly && !div_busy) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    exp_rv = '0;
    if (m_fly && cyc >= m_gc + m_lat) exp_rv[m_idx] = 1'b1;
    chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
    if (exp_rv != '0) begin
      chk("resp_idx", 64'(resp_idx), 64'(m_idx));
      chk("resp_quotient", 64'(resp_quotient), 64'(m_q));
      chk("resp_remainder", 64'(resp_remainder), 64'(m_r));
      chk("resp_error", 64'(resp_error), 64'(m_err));
    end
    exp_st = m_fly && m_good && (cyc == m_gc + 1);
    chk("div_start", 64'(div_start), 64'(exp_st));
    if (exp_st) begin
      chk("div_dividend", 64'(div_dividend), 64'(m_a));
      chk("div_divisor", 64'(div_divisor), 64'(m_b));
    end
    if (exp_rv != '0 && resp_ready[m_idx]) begin
      last_q   = resp_quotient;
      last_r   = resp_remainder;
      last_err = resp_error;
      last_idx = resp_idx;
      m_fly    = 1'b0;
      n_done++;
    end
    if (g >= 0) begin
      m_fly  = 1'b1;
      m_idx  = g;
      m_gc   = cyc;
      m_ptr  = g;
      m_a    = opa[g];
      m_b    = opb[g];
      glog.push_back(g);
      m_good = m_a[W-1] && m_b[W-1];
      m_hang = (hang_mode == 1) || (hang_mode == 2 && $urandom_range(0, 7) == 0);
      if (!m_good) begin
        m_lat = 1;      m_err = 1'b1; m_q = '0; m_r = '0;
      end else if (m_hang) begin
        m_lat = 2 + TO; m_err = 1'b1; m_q = '0; m_r = '0;
      end else begin
        m_lat = 2 + D;  m_err = 1'b0; {m_q, m_r} = f_div(m_a, m_b);
      end
      if (!refill) want[g] = 1'b0;
    end
  endtask

  task automatic run_ops(input int target, input int limit);
    int k = 0;
    while (n_done < target && k < limit) begin
      step();
      k++;
    end
    chk("ops_done", 64'(n_done), 64'(target));
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((m_fly || want != '0) && k < limit) begin
      step();
      k++;
    end
    chk("drain_idle", 64'(m_fly || want != '0), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    want       = '0;
    req_valid  = '0;
    rr_drv     = '0;
    resp_ready = '0;
    busy_force = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_div_start", 64'(div_start), 64'(0));
    chk("rst_resp_error", 64'(resp_error), 64'(0));
    chk("rst_resp_data", {8'd0, resp_quotient, resp_remainder}, 64'(0));
    chk("rst_resp_idx", 64'(resp_idx), 64'(0));
    chk("rst_div_ops", {16'd0, div_dividend, div_divisor}, 64'(0));
    m_fly = 1'b0;
    m_ptr = N - 1;
    glog.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int k;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    do_reset();

    // Single op on requester 0.
    rr_drv = '1;
    opa[0] = 24'hC00000; opb[0] = 24'h800000; want = 4'b0001;
    run_ops(n_done + 1, 200);
    chk("t1_quotient", 64'(last_q), 64'h0C00000);
    chk("t1_remainder", 64'(last_r), 64'(0));
    chk("t1_error", 64'(last_err), 64'(0));

    // Remainder path on requester 2.
    opa[2] = 24'h800000; opb[2] = 24'hC00000; want = 4'b0100;
    run_ops(n_done + 1, 200);
    chk("t2_quotient", 64'(last_q), 64'h0555555);
    chk("t2_remainder", 64'(last_r), 64'h0400000);
    chk("t2_idx", 64'(last_idx), 64'(2));

    // Round-robin from reset with every requester always valid.
    do_reset();
    for (int i = 0; i < N; i++) begin
      opa[i] = 24'hC00000; opb[i] = 24'h900000;
    end
    rr_drv = '1; refill = 1'b1; want = '1;
    k = 0;
    while (glog.size() < 5 && k < 400) begin step(); k++; end
    refill = 1'b0; want = '0;
    drain(200);
    chk("rr_count", 64'(glog.size() >= 5), 64'(1));
    if (glog.size() >= 5) begin
      chk("rr_order0", 64'(glog[0]), 64'(0));
      chk("rr_order1", 64'(glog[1]), 64'(1));
      chk("rr_order2", 64'(glog[2]), 64'(2));
      chk("rr_order3", 64'(glog[3]), 64'(3));
      chk("rr_order4", 64'(glog[4]), 64'(0));
    end

    // Operand fault: unnormalized divisor.
    opa[1] = 24'hC00000; opb[1] = 24'h400000; want = 4'b0010;
    run_ops(n_done + 1, 50);
    chk("fault_error", 64'(last_err), 64'(1));
    chk("fault_data", {8'd0, last_q, last_r}, 64'(0));

    // Divider never completes.
    hang_mode = 1;
    opa[3] = 24'hF00000; opb[3] = 24'h880000; want = 4'b1000;
    run_ops(n_done + 1, 300);
    hang_mode = 0;
    chk("timeout_error", 64'(last_err), 64'(1));

    // Backpressure: hold resp_ready low while others keep requesting.
    rr_drv = '0;
    for (int i = 0; i < N; i++) begin
      opa[i] = rnd_op() | 24'h800000; opb[i] = rnd_op() | 24'h800000;
    end
    want = 4'b0111;
    k = 0;
    while (!(m_fly && cyc >= m_gc + m_lat) && k < 200) begin step(); k++; end
    repeat (10) step();
    rr_drv = '1;
    drain(400);

    // Randomized traffic with random backpressure, faults, hangs and busy.
    rnd_mode = 1'b1; hang_mode = 2;
    repeat (1500) step();
    rnd_mode = 1'b0; hang_mode = 0; busy_force = 1'b0; want = '0; rr_drv = '1;
    drain(400);

    // Reset while waiting on the divider, then a clean op from requester 0.
    hang_mode = 1;
    opa[0] = 24'hA00000; opb[0] = 24'hE00000; want = 4'b0001;
    k = 0;
    while (!(m_fly && cyc == m_gc + 6) && k < 100) begin step(); k++; end
    do_reset();
    hang_mode = 0;
    opa[0] = 24'hA00000; opb[0] = 24'hE00000;
    opa[3] = 24'hFFFFFF; opb[3] = 24'h800001;
    want = 4'b1001; rr_drv = '1;
    run_ops(n_done + 1, 200);
    chk("rst_first_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'(0));
    chk("rst_next_error", 64'(last_err), 64'(0));
    drain(200);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one multi-cycle normalized-mantissa divider between NUM_REQ requesters, e.g. the FPU divide lanes.
- Arbitrates requests round-robin, screens operands, drives the divider's start/operand interface and waits for its done pulse.
- Returns the quotient and remainder to the granted requester over a valid/ready response handshake.
- A watchdog converts a hung divider into an error response.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- INWIDTH, 24: operand and remainder width.
- OUTWIDTH, 24: quotient width.
- TIMEOUT, 64: maximum cycles spent in WAIT before an error response is forced.
- IDXW, $clog2(NUM_REQ): width of requester index fields.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_dividend  in  NUM_REQ*INWIDTH  packed dividends; requester i occupies slice i.
- req_divisor  in  NUM_REQ*INWIDTH  packed divisors; requester i occupies slice i.
- resp_valid  out  NUM_REQ  per-requester response valid; at most one bit high.
- resp_ready  in  NUM_REQ  per-requester response accept.
- resp_quotient  out  OUTWIDTH  shared response quotient.
- resp_remainder  out  INWIDTH  shared response remainder.
- resp_error  out  1  high when the response is an operand fault or a timeout.
- resp_idx  out  IDXW  index of the responding requester.
- div_start  out  1  one-cycle start pulse to the divider.
- div_dividend  out  INWIDTH  divider dividend, registered.
- div_divisor  out  INWIDTH  divider divisor, registered.
- div_busy  in  1  divider busy.
- div_done  in  1  divider done pulse.
- div_quotient  in  OUTWIDTH  divider quotient; valid in the div_done cycle and after.
- div_remainder  in  INWIDTH  divider remainder; valid in the div_done cycle and after.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - req_ready, resp_valid, div_start, resp_error and all data/index registers clear to 0.
  - RR pointer goes to NUM_REQ-1, so requester 0 wins first.
  - Watchdog counter clears to 0.
- Reset asserted mid-operation aborts the transaction silently; no response is ever produced for it. The divider is assumed reset by the same reset_n.
- FSM has four states: IDLE, START, WAIT, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i] high, searching from ptr+1 upward and wrapping modulo NUM_REQ.
  - The grant is taken only when div_busy=0; if div_busy=1 no grant is made.
  - On a grant, req_ready[g]=1 combinationally in the same cycle and the transfer completes that cycle.
  - In the grant cycle: latch operands into div_dividend/div_divisor, set gidx<=g and ptr<=g.
  - If either operand's bit INWIDTH-1 is 0, go to RESP with error=1, quotient=0 and remainder=0; the divider is never started.
  - Otherwise go to START.
- START: div_start=1 for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT:
  - The watchdog increments every cycle.
  - On div_done=1, capture div_quotient/div_remainder, set error=0 and go to RESP.
  - If the watchdog reaches TIMEOUT before done arrives, set error=1, zero the data and go to RESP. A later stray div_done is ignored.
  - If div_done and the timeout occur in the same cycle, div_done wins.
- RESP:
  - resp_valid[gidx]=1 and resp_idx=gidx; resp data are held stable.
  - On resp_ready[gidx]=1, go to IDLE. No new grant is made in that same cycle, so the minimum gap between grants is 1 IDLE cycle.
  - resp_ready on non-granted indices is ignored.
- Latency: grant to resp_valid is 2 + D cycles for a good operation, where D is the start-to-done latency (OUTWIDTH+1 for the 24-bit divider). A fault response appears 1 cycle after the grant.
- Throughput: one operation in flight; no queueing.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 other transactions before it is granted.
- Requesters must hold req_valid and operands stable until req_ready; withdrawal before grant is allowed.

Test Plan:
- Single op: req 0 with dividend 0xC00000, divisor 0x800000 -> one div_start 1 cycle after the grant; resp_valid[0] with quotient 0xC00000, remainder 0, error 0.
- Remainder path: req 2 with dividend 0x800000, divisor 0xC00000 -> quotient 0x555555, remainder 0x400000, resp_idx=2.
- Round-robin: all 4 requesters hold valid from reset, each with resp_ready=1 -> grant order 0,1,2,3,0; no requester is granted twice before all others.
- Operand fault: divisor 0x400000 -> resp_valid 1 cycle after the grant with error=1, data 0, and div_start never asserted.
- Timeout and backpressure: divider model never asserts done -> error response after exactly TIMEOUT WAIT cycles. Separately, holding resp_ready low for 10 cycles keeps resp_valid and data stable and blocks new grants.
- Reset mid-WAIT: pull reset_n low during WAIT -> all outputs are 0 immediately; after release the next grant goes to req 0 and completes normally.
